// File: rtl/load_store_unit_if.sv
// Bundle of request, Memory and response signals between the execute stage,
// the load/store unit and the byte-addressed data Memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic [31:0] mem_address;
    logic [31:0] mem_wr_data;
    logic        mem_wr_enable;
    logic [2:0]  mem_write_length;
    logic [31:0] mem_read_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_error;

    // Environment side: execute stage plus the Memory.
    modport master (
        output req_valid, req_is_store, req_funct3, req_address, req_wdata,
        input  req_ready,
        input  mem_address, mem_wr_data, mem_wr_enable, mem_write_length,
        output mem_read_data,
        input  resp_valid, resp_data, resp_error,
        output resp_ready
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_is_store, req_funct3, req_address, req_wdata,
        output req_ready,
        output mem_address, mem_wr_data, mem_wr_enable, mem_write_length,
        input  mem_read_data,
        output resp_valid, resp_data, resp_error,
        input  resp_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store bridge: checks legality, drives one Memory
// access cycle, then returns the aligned/extended load result or an error.
module load_store_unit #(
    parameter int unsigned MEMORY_SIZE_BYTES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   lsu
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_error;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_wr_data;
    logic        r_mem_wr_enable;
    logic [2:0]  r_mem_write_length;

    logic [32:0] w_size;
    logic [32:0] w_last;
    logic        w_funct3_ok;
    logic        w_align_ok;
    logic        w_range_ok;
    logic        w_legal;
    logic [31:0] w_load_ext;

    // Range check runs at 33 bits so addresses near 2^32 cannot wrap to legal.
    always_comb begin
        w_size      = 33'd1 << lsu.req_funct3[1:0];
        w_last      = {1'b0, lsu.req_address} + w_size - 33'd1;
        w_range_ok  = w_last < 33'(MEMORY_SIZE_BYTES);
        w_funct3_ok = lsu.req_is_store ? (lsu.req_funct3 <= 3'd2)
                                       : (lsu.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        w_align_ok  = 1'b1;
        if (lsu.req_funct3[1:0] == 2'd1)
            w_align_ok = (lsu.req_address[0] == 1'b0);
        else if (lsu.req_funct3[1:0] == 2'd2)
            w_align_ok = (lsu.req_address[1:0] == 2'b00);
        w_legal = w_funct3_ok && w_align_ok && w_range_ok;
    end

    always_comb begin
        w_load_ext = lsu.mem_read_data;
        unique case (r_funct3)
            3'd0:    w_load_ext = {{24{lsu.mem_read_data[7]}}, lsu.mem_read_data[7:0]};
            3'd4:    w_load_ext = {24'd0, lsu.mem_read_data[7:0]};
            3'd1:    w_load_ext = {{16{lsu.mem_read_data[15]}}, lsu.mem_read_data[15:0]};
            3'd5:    w_load_ext = {16'd0, lsu.mem_read_data[15:0]};
            default: w_load_ext = lsu.mem_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= IDLE;
            r_is_store         <= 1'b0;
            r_funct3           <= '0;
            r_req_ready        <= 1'b1;
            r_resp_valid       <= 1'b0;
            r_resp_data        <= '0;
            r_resp_error       <= 1'b0;
            r_mem_address      <= '0;
            r_mem_wr_data      <= '0;
            r_mem_wr_enable    <= 1'b0;
            r_mem_write_length <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (lsu.req_valid) begin
                        r_is_store  <= lsu.req_is_store;
                        r_funct3    <= lsu.req_funct3;
                        r_req_ready <= 1'b0;
                        if (w_legal) begin
                            // Memory outputs are loaded here so they are valid throughout ACCESS.
                            r_mem_address      <= lsu.req_address;
                            r_mem_wr_data      <= lsu.req_wdata;
                            r_mem_write_length <= {1'b0, lsu.req_funct3[1:0]};
                            r_mem_wr_enable    <= lsu.req_is_store;
                            r_state            <= ACCESS;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                            r_resp_data  <= '0;
                            r_state      <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    r_mem_wr_enable <= 1'b0;
                    r_resp_valid    <= 1'b1;
                    r_resp_error    <= 1'b0;
                    r_resp_data     <= r_is_store ? '0 : w_load_ext;
                    r_state         <= RESP;
                end
                RESP: begin
                    if (lsu.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lsu.req_ready        = r_req_ready;
    assign lsu.resp_valid       = r_resp_valid;
    assign lsu.resp_data        = r_resp_data;
    assign lsu.resp_error       = r_resp_error;
    assign lsu.mem_address      = r_mem_address;
    assign lsu.mem_wr_data      = r_mem_wr_data;
    assign lsu.mem_wr_enable    = r_mem_wr_enable;
    assign lsu.mem_write_length = r_mem_write_length;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array Memory model
// (combinational little-endian read, posedge write by write_length).
module tb_load_store_unit;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   we_cnt;
    logic [2:0] last_len;
    logic [7:0] mem [0:4095];

    load_store_unit_if bus ();

    load_store_unit #(.MEMORY_SIZE_BYTES(4096)) dut (
        .clk   (clk),
        .reset (reset),
        .lsu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] a0, a1, a2, a3;
    always_comb begin
        a0 = bus.mem_address[11:0];
        a1 = a0 + 12'd1;
        a2 = a0 + 12'd2;
        a3 = a0 + 12'd3;
        bus.mem_read_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
    end

    always @(posedge clk) begin
        if (bus.mem_wr_enable) begin
            we_cnt   = we_cnt + 1;
            last_len = bus.mem_write_length;
            mem[a0] <= bus.mem_wr_data[7:0];
            if (bus.mem_write_length != 3'd0) mem[a1] <= bus.mem_wr_data[15:8];
            if (bus.mem_write_length == 3'd2) begin
                mem[a2] <= bus.mem_wr_data[23:16];
                mem[a3] <= bus.mem_wr_data[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] d, output logic e,
                          output int lat, output int wes);
        int we0;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_address  = a;
        bus.req_wdata    = wd;
        we0 = we_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.resp_data;
        e = bus.resp_error;
        @(posedge clk); #1;
        wes = we_cnt - we0;
    endtask

    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic        e;
        int          lat;
        int          wes;
        do_req(st, f3, a, wd, d, e, lat, wes);
        check({tag, ".data"}, d, exp_d);
        check({tag, ".err"}, 32'(e), 32'(exp_e));
        check({tag, ".lat"}, 32'(lat), exp_e ? 32'd1 : 32'd2);
        check({tag, ".we"}, 32'(wes), (st && !exp_e) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          wes;
        n_vec = 0;
        n_err = 0;
        we_cnt = 0;
        last_len = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        bus.req_valid = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3 = '0;
        bus.req_address = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.resp_data", bus.resp_data, 32'd0);
        check("rst.resp_error", 32'(bus.resp_error), 32'd0);
        check("rst.mem_we", 32'(bus.mem_wr_enable), 32'd0);
        check("rst.mem_addr", bus.mem_address, 32'd0);
        check("rst.mem_wdata", bus.mem_wr_data, 32'd0);
        check("rst.mem_len", 32'(bus.mem_write_length), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        check("sw10.len", 32'(last_len), 32'd2);
        run("lw10", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        run("sb21", 1'b1, 3'd0, 32'h21, 32'h80, 32'h0, 1'b0);
        check("sb21.len", 32'(last_len), 32'd0);
        run("lb21", 1'b0, 3'd0, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
        run("lbu21", 1'b0, 3'd4, 32'h21, 32'h0, 32'h00000080, 1'b0);

        run("sh30", 1'b1, 3'd1, 32'h30, 32'h8001, 32'h0, 1'b0);
        check("sh30.len", 32'(last_len), 32'd1);
        run("lh30", 1'b0, 3'd1, 32'h30, 32'h0, 32'hFFFF8001, 1'b0);
        run("lhu30", 1'b0, 3'd5, 32'h30, 32'h0, 32'h00008001, 1'b0);
        run("lw32mis", 1'b0, 3'd2, 32'h32, 32'h0, 32'h0, 1'b1);
        run("sh31mis", 1'b1, 3'd1, 32'h31, 32'h1234, 32'h0, 1'b1);

        run("lwffc", 1'b0, 3'd2, 32'hFFC, 32'h0, 32'h0, 1'b0);
        run("lw1000", 1'b0, 3'd2, 32'h1000, 32'h0, 32'h0, 1'b1);
        run("lwtop", 1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1);
        run("lbufff", 1'b0, 3'd4, 32'hFFF, 32'h0, 32'h0, 1'b0);
        run("lhffe", 1'b0, 3'd1, 32'hFFE, 32'h0, 32'h0, 1'b0);
        run("sf3_4", 1'b1, 3'd4, 32'h40, 32'h55, 32'h0, 1'b1);
        run("lf3_3", 1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 1'b1);

        // Back-pressure: response held, new request waits for the handshake.
        bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3 = 3'd2;
        bus.req_address = 32'h10;
        @(posedge clk); #1;
        bus.req_funct3 = 3'd4;
        bus.req_address = 32'h21;
        @(posedge clk); #1;
        check("bp.valid0", 32'(bus.resp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.valid", 32'(bus.resp_valid), 32'd1);
            check("bp.data", bus.resp_data, 32'hDEADBEEF);
            check("bp.err", 32'(bus.resp_error), 32'd0);
            check("bp.req_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.hs_valid", 32'(bus.resp_valid), 32'd0);
        check("bp.hs_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        check("bp.acc_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("bp.next_valid", 32'(bus.resp_valid), 32'd1);
        check("bp.next_data", bus.resp_data, 32'h00000080);
        @(posedge clk); #1;

        // Reset while a store is in its ACCESS cycle.
        run("sw40old", 1'b1, 3'd2, 32'h40, 32'h11111111, 32'h0, 1'b0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_is_store = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_address = 32'h40;
        bus.req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rsta.we_access", 32'(bus.mem_wr_enable), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rsta.we", 32'(bus.mem_wr_enable), 32'd0);
        check("rsta.req_ready", 32'(bus.req_ready), 32'd1);
        check("rsta.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rsta.resp_data", bus.resp_data, 32'd0);
        check("rsta.resp_error", 32'(bus.resp_error), 32'd0);
        check("rsta.mem_addr", bus.mem_address, 32'd0);
        check("rsta.mem_wdata", bus.mem_wr_data, 32'd0);
        check("rsta.mem_len", 32'(bus.mem_write_length), 32'd0);
        @(posedge clk); #1;
        check("rsta.we_hold", 32'(bus.mem_wr_enable), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_req(1'b0, 3'd2, 32'h40, 32'h0, d, e, lat, wes);
        check("rsta.whole", 32'((d == 32'h11111111) || (d == 32'hAABBCCDD)), 32'd1);
        check("rsta.lw_err", 32'(e), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
